// File: rtl/pulse_meter_pkg.sv
// Shared types and widths for the pulse rate meter slice.
package pulse_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int STEP_W          = 14;
    localparam int RATE_W          = 8;
    localparam int CNT_MAX_DEFAULT = 9999;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous pulse, followed by a registered rising-edge detector.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_edge
);

    logic sync_a;
    logic sync_b;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_a <= async_in;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    assign rise_edge = sync_b & ~prev;

endmodule

// File: rtl/pulse_rate_meter.sv
// Step counter and per-window rate meter for an asynchronous pulse train.
// Define PULSE_RATE_METER_HIGH_ACT_EN to build the high-activity seconds counter.
module pulse_rate_meter
    import pulse_meter_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int CNT_MAX      = CNT_MAX_DEFAULT,
    parameter int HIGH_RATE    = 32,
    parameter int IDLE_WINDOWS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              clear,
    output logic [STEP_W-1:0] step_count,
    output logic              step_sat,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic [RATE_W-1:0] high_act_secs,
    output logic              active
);

    localparam int WIN_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int EMPTY_W = $clog2(IDLE_WINDOWS + 1);

    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(CLK_HZ - 1);
    localparam logic [STEP_W-1:0]  STEP_MAX   = STEP_W'(CNT_MAX);
    localparam logic [EMPTY_W-1:0] EMPTY_LAST = EMPTY_W'(IDLE_WINDOWS - 1);

    if (CLK_HZ < 2 || IDLE_WINDOWS < 1 || CNT_MAX < 1 || CNT_MAX >= (2 ** STEP_W) ||
        HIGH_RATE < 0 || HIGH_RATE > 255) begin : g_bad_params
        $error("pulse_rate_meter: unsupported parameter set");
    end

    state_t             state, state_next;
    logic               step_edge;
    logic [WIN_W-1:0]   win_cnt, win_cnt_next;
    logic [RATE_W-1:0]  win_steps, win_steps_next;
    logic [EMPTY_W-1:0] empty_cnt, empty_cnt_next;
    logic [RATE_W-1:0]  rate_next;
    logic               rate_valid_next;
    logic [STEP_W-1:0]  step_count_next;

    pulse_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_in  (pulse_in),
        .rise_edge (step_edge)
    );

    // An edge coincident with the terminal count opens the next window, so it
    // restarts the run even when the closing window would otherwise go idle.
    always_comb begin
        state_next      = state;
        win_cnt_next    = win_cnt;
        win_steps_next  = win_steps;
        empty_cnt_next  = empty_cnt;
        rate_next       = rate;
        rate_valid_next = 1'b0;
        case (state)
            IDLE: begin
                win_cnt_next   = '0;
                win_steps_next = '0;
                empty_cnt_next = '0;
                rate_next      = '0;
                if (step_edge) begin
                    state_next     = RUN;
                    win_steps_next = RATE_W'(1);
                end
            end
            RUN: begin
                if (win_cnt == WIN_LAST) begin
                    rate_valid_next = 1'b1;
                    rate_next       = win_steps;
                    win_cnt_next    = '0;
                    win_steps_next  = step_edge ? RATE_W'(1) : '0;
                    if (win_steps != '0) begin
                        empty_cnt_next = '0;
                    end else if (empty_cnt != EMPTY_LAST) begin
                        empty_cnt_next = empty_cnt + 1'b1;
                    end else begin
                        empty_cnt_next = '0;
                        if (!step_edge) state_next = IDLE;
                    end
                end else begin
                    win_cnt_next = win_cnt + 1'b1;
                    if (step_edge && win_steps != '1) win_steps_next = win_steps + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        step_count_next = step_count;
        if (step_edge && step_count != STEP_MAX) step_count_next = step_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= IDLE;
            win_cnt    <= '0;
            win_steps  <= '0;
            empty_cnt  <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            step_count <= '0;
            step_sat   <= 1'b0;
        end else begin
            state      <= state_next;
            win_cnt    <= win_cnt_next;
            win_steps  <= win_steps_next;
            empty_cnt  <= empty_cnt_next;
            rate       <= rate_next;
            rate_valid <= rate_valid_next;
            step_count <= step_count_next;
            if (step_count_next == STEP_MAX) step_sat <= 1'b1;
        end
    end

    assign active = (state == RUN);

`ifdef PULSE_RATE_METER_HIGH_ACT_EN
    localparam int HI_W = RATE_W + 1;
    localparam logic [HI_W-1:0] HIGH_TH = HI_W'(HIGH_RATE);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            high_act_secs <= '0;
        end else if (rate_valid_next && ({1'b0, win_steps} >= HIGH_TH) &&
                     (high_act_secs != '1)) begin
            high_act_secs <= high_act_secs + 1'b1;
        end
    end
`else
    assign high_act_secs = '0;
`endif

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Randomized scoreboard bench for pulse_rate_meter with an edge-time based window model.
module tb_pulse_rate_meter;

    localparam int CLK_HZ       = 100;
    localparam int CNT_MAX      = 20;
    localparam int HIGH_RATE    = 8;
    localparam int IDLE_WINDOWS = 4;
`ifdef PULSE_RATE_METER_HIGH_ACT_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse_in;
    logic        clear;
    logic [13:0] step_count;
    logic        step_sat;
    logic [7:0]  rate;
    logic        rate_valid;
    logic [7:0]  high_act_secs;
    logic        active;

    typedef struct {
        int cyc;
        int rate;
        int hi;
        int cnt;
        int sat;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;
    bit  pat[$];
    int  e_list[$];
    int  run_start[$];
    int  run_stop[$];
    int  cyc = 0;
    int  checks = 0;
    int  passed = 0;

    pulse_rate_meter #(
        .CLK_HZ       (CLK_HZ),
        .CNT_MAX      (CNT_MAX),
        .HIGH_RATE    (HIGH_RATE),
        .IDLE_WINDOWS (IDLE_WINDOWS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pulse_in      (pulse_in),
        .clear         (clear),
        .step_count    (step_count),
        .step_sat      (step_sat),
        .rate          (rate),
        .rate_valid    (rate_valid),
        .high_act_secs (high_act_secs),
        .active        (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, actual, expected, cyc);
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, "_step_count"}, int'(step_count), 0);
        check_output({tag, "_step_sat"}, int'(step_sat), 0);
        check_output({tag, "_rate"}, int'(rate), 0);
        check_output({tag, "_rate_valid"}, int'(rate_valid), 0);
        check_output({tag, "_high_act_secs"}, int'(high_act_secs), 0);
        check_output({tag, "_active"}, int'(active), 0);
    endtask

    function automatic int count_steps(input int k);
        int n = 0;
        foreach (e_list[i]) if (e_list[i] <= k) n++;
        return n;
    endfunction

    function automatic int exp_active(input int k);
        foreach (run_start[r]) if (run_start[r] <= k && k < run_stop[r]) return 1;
        return 0;
    endfunction

    task automatic add_level(input bit v, input int n);
        for (int i = 0; i < n; i++) pat.push_back(v);
    endtask

    // Steps land 3 cycles after the drive cycle; windows are CLK_HZ cycles long,
    // anchored on the first step of a run; the clear at the end discards later windows.
    task automatic build_model(input int base);
        int  tend, i, t, close, cnt, empty, hi, rate_e, total;
        bit  lvl, done, running;
        ev_t ev;
        tend = base + pat.size() + 1;
        lvl  = 1'b0;
        e_list.delete();
        run_start.delete();
        run_stop.delete();
        foreach (pat[j]) begin
            if (pat[j] && !lvl) e_list.push_back(base + j + 3);
            lvl = pat[j];
        end
        hi = 0;
        i = 0;
        done = 1'b0;
        while (!done && i < e_list.size()) begin
            t = e_list[i];
            run_start.push_back(t);
            empty = 0;
            running = 1'b1;
            while (running) begin
                close = t + CLK_HZ;
                if (close >= tend) begin
                    run_stop.push_back(tend + 1000);
                    running = 1'b0;
                    done = 1'b1;
                end else begin
                    cnt = 0;
                    while (i < e_list.size() && e_list[i] < close) begin
                        cnt++;
                        i++;
                    end
                    rate_e = (cnt > 255) ? 255 : cnt;
                    if (HIGH_EN && rate_e >= HIGH_RATE && hi < 255) hi++;
                    total = count_steps(close);
                    ev.cyc  = close;
                    ev.rate = rate_e;
                    ev.hi   = hi;
                    ev.cnt  = (total > CNT_MAX) ? CNT_MAX : total;
                    ev.sat  = (total >= CNT_MAX) ? 1 : 0;
                    sb.push_back(ev);
                    empty = (cnt == 0) ? empty + 1 : 0;
                    if (empty == IDLE_WINDOWS) begin
                        run_stop.push_back(close);
                        running = 1'b0;
                    end
                    t = close;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input string tag);
        int base, total;
        @(negedge clk);
        base = cyc;
        build_model(base);
        for (int j = 0; j < pat.size(); j++) begin
            if (j > 0) @(negedge clk);
            total = count_steps(cyc);
            check_output({tag, "_step_count"}, int'(step_count), (total > CNT_MAX) ? CNT_MAX : total);
            check_output({tag, "_step_sat"}, int'(step_sat), (total >= CNT_MAX) ? 1 : 0);
            check_output({tag, "_active"}, int'(active), exp_active(cyc));
            pulse_in = pat[j];
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_zero({tag, "_clear"});
        check_output({tag, "_scoreboard_drained"}, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rate_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("spurious_rate_valid", int'(rate_valid), 0);
            end else begin
                mon_ev = sb.pop_front();
                check_output("rate_valid_cycle", cyc, mon_ev.cyc);
                check_output("rate", int'(rate), mon_ev.rate);
                check_output("high_act_secs", int'(high_act_secs), mon_ev.hi);
                check_output("window_step_count", int'(step_count), mon_ev.cnt);
                check_output("window_step_sat", int'(step_sat), mon_ev.sat);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        pulse_in = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_zero("reset");
            pulse_in = ~pulse_in;
            @(negedge clk);
        end
        pulse_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_zero("reset");
            @(negedge clk);
        end
        rst = 1'b0;

        // Steady 10-cycle period, saturation, idle after four empty windows, then restart.
        pat.delete();
        add_level(1'b0, 5);
        for (int i = 0; i < 35; i++) begin
            add_level(1'b1, 5);
            add_level(1'b0, 5);
        end
        add_level(1'b0, 520);
        add_level(1'b1, 5);
        add_level(1'b0, 150);
        apply_stimulus("steady");

        // Second window's first edge lands exactly on the terminal-count cycle.
        pat.delete();
        add_level(1'b0, 2);
        add_level(1'b1, 5);
        add_level(1'b0, 95);
        add_level(1'b1, 5);
        add_level(1'b0, 43);
        add_level(1'b1, 5);
        add_level(1'b0, 60);
        apply_stimulus("coincident");

        pat.delete();
        add_level(1'b0, 3);
        for (int i = 0; i < 40; i++) begin
            add_level(1'b1, int'($urandom_range(12, 2)));
            add_level(1'b0, int'($urandom_range(12, 2)));
        end
        add_level(1'b0, 60);
        apply_stimulus("random");

        // 25 edges with a clear in the middle of the second window.
        pat.delete();
        add_level(1'b0, 2);
        for (int i = 0; i < 25; i++) begin
            add_level(1'b1, 3);
            add_level(1'b0, 3);
        end
        add_level(1'b0, 4);
        apply_stimulus("midclear");

        pat.delete();
        add_level(1'b0, 250);
        apply_stimulus("quiet");

        check_output("final_scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
